// File: rtl/music_player_pkg.sv
// ----------------------------------------------------------------------------
// music_pkg : shared constants, note periods (50 MHz clk) and state type
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package music_pkg;

  localparam int ADDR_W    = 9;
  localparam int NOTE_W    = 33;
  localparam int SONG_LEN  = 384;
  localparam int REST_CODE = 2500;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Full-period lengths in clk cycles; D* is the octave below M*, H*/HH* above.
  localparam logic [NOTE_W-1:0] D5  = 33'd255102;
  localparam logic [NOTE_W-1:0] D6  = 33'd227273;
  localparam logic [NOTE_W-1:0] D7  = 33'd202478;
  localparam logic [NOTE_W-1:0] M1  = 33'd191110;
  localparam logic [NOTE_W-1:0] M2  = 33'd170265;
  localparam logic [NOTE_W-1:0] M3  = 33'd151685;
  localparam logic [NOTE_W-1:0] M4  = 33'd143172;
  localparam logic [NOTE_W-1:0] M5  = 33'd127551;
  localparam logic [NOTE_W-1:0] M6  = 33'd113636;
  localparam logic [NOTE_W-1:0] M7  = 33'd101239;
  localparam logic [NOTE_W-1:0] H1  = 33'd95555;
  localparam logic [NOTE_W-1:0] H2  = 33'd85131;
  localparam logic [NOTE_W-1:0] H3  = 33'd75843;
  localparam logic [NOTE_W-1:0] H4  = 33'd71586;
  localparam logic [NOTE_W-1:0] H5  = 33'd63776;
  localparam logic [NOTE_W-1:0] H6  = 33'd56818;
  localparam logic [NOTE_W-1:0] H7  = 33'd50620;
  localparam logic [NOTE_W-1:0] HH1 = 33'd47778;
  localparam logic [NOTE_W-1:0] HH2 = 33'd42566;
  localparam logic [NOTE_W-1:0] M1S = 33'd180388;
  localparam logic [NOTE_W-1:0] M4S = 33'd135137;
  localparam logic [NOTE_W-1:0] M5S = 33'd120395;
  localparam logic [NOTE_W-1:0] H1S = 33'd90194;
  localparam logic [NOTE_W-1:0] H4S = 33'd67569;

endpackage

`default_nettype wire

// File: rtl/music_player_tone_gen.sv
// ----------------------------------------------------------------------------
// tone_gen : free-running period counter producing a 50 % duty square wave
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tone_gen #(
  parameter int NOTE_W = music_pkg::NOTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [NOTE_W-1:0] period,
  output logic              wave
);

  logic [NOTE_W-1:0] cnt_q;
  logic [NOTE_W-1:0] cnt_d;

  // A zero period simply parks the counter at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if ((period == '0) || (cnt_q >= (period - 1'b1))) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wave = (cnt_q < (period >> 1));

endmodule

`default_nettype wire

// File: rtl/music_player.sv
// ----------------------------------------------------------------------------
// music_player : steps a song ROM once per beat and drives a square-wave buzzer.
// Define MUSIC_PLAYER_ARTIC_EN to silence the tail of every beat.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module music_player #(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int ROM_LAT     = 1,
  parameter int ADDR_W      = music_pkg::ADDR_W,
  parameter int NOTE_W      = music_pkg::NOTE_W,
  parameter int SONG_LEN    = music_pkg::SONG_LEN,
  parameter int REST_CODE   = music_pkg::REST_CODE
`ifdef MUSIC_PLAYER_ARTIC_EN
  ,
  parameter int ARTIC_CYCLES = BEAT_CYCLES / 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [NOTE_W-1:0] rom_note,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              buzzer,
  output logic              playing,
  output logic              done
);

  import music_pkg::*;

  localparam int                 BEAT_W    = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [BEAT_W-1:0]  LATCH_AT  = BEAT_W'(ROM_LAT);
  localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(SONG_LEN - 1);
  localparam logic [NOTE_W-1:0]  REST_N    = NOTE_W'(REST_CODE);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [BEAT_W-1:0] beat_q,  beat_d;
  logic [NOTE_W-1:0] note_q,  note_d;
  logic              tone_clear;
  logic              tone_wave;
  logic              beat_end;
  logic              gap;

  assign beat_end = (beat_q == BEAT_LAST);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    note_d     = note_q;
    tone_clear = 1'b0;

    if (stop) begin
      state_d = IDLE;
      addr_d  = '0;
      beat_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = FETCH;
            addr_d     = '0;
            beat_d     = '0;
            note_d     = '0;
            tone_clear = 1'b1;
          end
        end

        FETCH, PLAY: begin
          beat_d = beat_end ? '0 : beat_q + 1'b1;
          // The ROM word for addr_q is valid once ROM_LAT edges have passed.
          if ((state_q == FETCH) && (beat_q == LATCH_AT)) begin
            note_d     = rom_note;
            tone_clear = 1'b1;
            if (rom_note == '0) begin
              if (loop_en) begin
                state_d = FETCH;
                addr_d  = '0;
                beat_d  = '0;
              end else begin
                state_d = DONE;
                beat_d  = '0;
              end
            end else begin
              state_d = PLAY;
            end
          end else if (beat_end) begin
            state_d = FETCH;
            if (addr_q == ADDR_LAST) begin
              addr_d = '0;
              if (!loop_en) begin
                state_d = DONE;
              end
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end
        end

        DONE: begin
          state_d = IDLE;
          addr_d  = '0;
          beat_d  = '0;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      note_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      note_q  <= note_d;
    end
  end

  tone_gen #(
    .NOTE_W (NOTE_W)
  ) u_tone_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tone_clear),
    .enable (playing),
    .period (note_q),
    .wave   (tone_wave)
  );

`ifdef MUSIC_PLAYER_ARTIC_EN
  assign gap = (ARTIC_CYCLES > 0) && (int'(beat_q) >= (BEAT_CYCLES - ARTIC_CYCLES));
`else
  assign gap = 1'b0;
`endif

  assign rom_addr = addr_q;
  assign playing  = (state_q == FETCH) || (state_q == PLAY);
  assign done     = (state_q == DONE);
  // A latched 0 (first fetch after start, or a looped song end) is silent like a rest.
  assign buzzer   = playing && (note_q != '0) && (note_q != REST_N) && tone_wave && !gap;

endmodule

`default_nettype wire

// File: tb/tb_music_player.sv
// ----------------------------------------------------------------------------
// tb_music_player : random songs checked against a timeline model of playback
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_music_player;

  localparam int BEAT     = 20;
  localparam int SONG_LEN = 8;
  localparam int REST     = 2500;
  localparam int MAXC     = 400;
`ifdef MUSIC_PLAYER_ARTIC_EN
  localparam int ARTIC    = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [32:0] rom_note;
  logic [8:0]  rom_addr;
  logic        buzzer, playing, done;

  logic [32:0] rom [512];

  int e_addr [MAXC];
  bit e_play [MAXC];
  bit e_done [MAXC];
  bit e_buz  [MAXC];

  int n_checks = 0;
  int n_errors = 0;

  music_player #(
    .BEAT_CYCLES (BEAT),
    .ROM_LAT     (1),
    .SONG_LEN    (SONG_LEN),
    .REST_CODE   (REST)
`ifdef MUSIC_PLAYER_ARTIC_EN
    ,
    .ARTIC_CYCLES(ARTIC)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .rom_note (rom_note),
    .rom_addr (rom_addr),
    .buzzer   (buzzer),
    .playing  (playing),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Song ROM with one edge of read latency.
  always @(posedge clk) rom_note <= rom[rom_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit tone_at(input int n, input int lat, input int c, input int k);
    if (n == 0 || n == REST) return 1'b0;
`ifdef MUSIC_PLAYER_ARTIC_EN
    if (k >= BEAT - ARTIC) return 1'b0;
`endif
    return ((c - lat) % n) < (n / 2);
  endfunction

  // Walk the song entry by entry and lay the expected outputs onto a timeline.
  // Cycle 0 is the first cycle after the start edge.
  task automatic build_model(input bit lp, input int stop_at);
    int  c = 0, a = 0, note = 0, lat = 0, n;
    bit  fin = 1'b0;
    for (int i = 0; i < MAXC; i++) begin
      e_addr[i] = 0; e_play[i] = 0; e_done[i] = 0; e_buz[i] = 0;
    end
    while (!fin && c < MAXC) begin
      for (int k = 0; k < 2; k++) begin
        if (c < MAXC) begin e_addr[c] = a; e_play[c] = 1; e_buz[c] = tone_at(note, lat, c, k); end
        c++;
      end
      n = int'(rom[a][31:0]);
      if (n == 0) begin
        if (lp) begin
          a = 0; note = 0; lat = c;
        end else begin
          if (c < MAXC) begin e_addr[c] = a; e_done[c] = 1; end
          fin = 1'b1;
        end
      end else begin
        note = n; lat = c;
        for (int k = 2; k < BEAT; k++) begin
          if (c < MAXC) begin e_addr[c] = a; e_play[c] = 1; e_buz[c] = tone_at(note, lat, c, k); end
          c++;
        end
        if (a == SONG_LEN - 1) begin
          a = 0;
          if (!lp) begin
            if (c < MAXC) e_done[c] = 1;
            fin = 1'b1;
          end
        end else begin
          a++;
        end
      end
    end
    for (int i = stop_at + 1; i < MAXC; i++) begin
      if (i >= 0) begin
        e_addr[i] = 0; e_play[i] = 0; e_done[i] = 0; e_buz[i] = 0;
      end
    end
  endtask

  task automatic run_song(input bit lp, input int ncyc, input int stop_at, input bit poke);
    build_model(lp, stop_at);
    loop_en = lp;
    @(negedge clk); start = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      check($sformatf("addr c%0d", c), rom_addr, e_addr[c]);
      check($sformatf("play c%0d", c), playing, e_play[c]);
      check($sformatf("done c%0d", c), done, e_done[c]);
      check($sformatf("buz c%0d", c), buzzer, e_buz[c]);
      if (c == stop_at) stop = 1'b1;
      else if (poke && c < stop_at && e_play[c] && $urandom_range(0, 15) == 0) start = 1'b1;
    end
    @(negedge clk); start = 1'b0; stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic load3(input int n0, input int n1, input int n2);
    for (int i = 0; i < 512; i++) rom[i] = '0;
    rom[0] = 33'(n0); rom[1] = 33'(n1); rom[2] = 33'(n2);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = '0;
    repeat (3) @(negedge clk);
    check("rst addr", rom_addr, 0);
    check("rst play", playing, 0);
    check("rst done", done, 0);
    check("rst buz", buzzer, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Tone, rest, end of song without and with looping.
    load3(8, REST, 0);
    run_song(1'b0, 60, 100000, 1'b0);
    run_song(1'b1, 140, 135, 1'b0);

    // Stop in the middle, then a clean replay from address 0.
    run_song(1'b0, 60, 30, 1'b0);
    run_song(1'b0, 60, 100000, 1'b1);

    // Start and stop together while idle: stop wins.
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    check("ss play", playing, 0);
    check("ss addr", rom_addr, 0);
    repeat (3) @(negedge clk);
    check("ss play late", playing, 0);

    // Repeated equal notes (articulation gap when enabled).
    load3(6, 6, 0);
    run_song(1'b0, 50, 100000, 1'b0);

    // Random songs, random loop mode, optional stop and ignored start pulses.
    for (int r = 0; r < 8; r++) begin
      int v;
      for (int i = 0; i < 512; i++) rom[i] = '0;
      for (int i = 0; i < SONG_LEN; i++) begin
        v = int'($urandom_range(0, 99));
        if (v < 8)       rom[i] = '0;
        else if (v < 20) rom[i] = 33'(REST);
        else if (v < 26) rom[i] = 33'd1;
        else if (v < 32) rom[i] = 33'($urandom_range(25, 3000));
        else             rom[i] = 33'($urandom_range(2, 24));
      end
      run_song(1'($urandom_range(0, 1)), MAXC,
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, MAXC - 1)) : 100000, 1'b1);
    end

    // Asynchronous reset while a note is playing.
    load3(8, 8, 0);
    loop_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (24) @(negedge clk);
    check("pre rst play", playing, 1);
    check("pre rst addr", rom_addr, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("async addr", rom_addr, 0);
    check("async play", playing, 0);
    check("async buz", buzzer, 0);
    check("async done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post rst play", playing, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
